// File: rtl/rptr_ctrl_param.sv
// rptr_ctrl_param: read-side pointer and flag controller for an asynchronous FIFO.
// Ports: rclk/rrst_n read clock and async active-low reset; r_en read request;
// g_wptr_async Gray write pointer from the write domain; b_rptr/g_rptr binary and
// Gray read pointers; raddr RAM read address; empty/almost_empty registered flags;
// rcount read-side occupancy; underflow one-cycle pulse on a read while empty.
module rptr_ctrl_param #(
   parameter int ADDR_WIDTH  = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AE_LEVEL    = 1
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  r_en,
   input  logic [ADDR_WIDTH:0]   g_wptr_async,
   output logic [ADDR_WIDTH:0]   b_rptr,
   output logic [ADDR_WIDTH:0]   g_rptr,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rcount,
   output logic                  underflow
);
   localparam int PW = ADDR_WIDTH + 1;
   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic [PW-1:0] g_wptr_sync, b_wptr_s, b_rptr_next, g_rptr_next, rcount_next;
   logic          rd_ok;
   always_ff @(posedge rclk or negedge rrst_n)
      if (!rrst_n)
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      else begin
         sync_q[0] <= g_wptr_async;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   assign g_wptr_sync = sync_q[SYNC_STAGES-1];
   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      b_wptr_s = '0;
      for (int i = 0; i < PW; i++) b_wptr_s[i] = ^(g_wptr_sync >> i);
   end
   assign rd_ok       = r_en & ~empty;
   assign b_rptr_next = b_rptr + PW'(rd_ok);
   assign g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1);
   assign rcount_next = b_wptr_s - b_rptr_next;
   // g_rptr comes straight from a flop since it is sampled by the write domain.
   always_ff @(posedge rclk or negedge rrst_n)
      if (!rrst_n) begin
         b_rptr       <= '0;
         g_rptr       <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rcount       <= '0;
         underflow    <= 1'b0;
      end else begin
         b_rptr       <= b_rptr_next;
         g_rptr       <= g_rptr_next;
         empty        <= g_rptr_next == g_wptr_sync;
         almost_empty <= rcount_next <= PW'(AE_LEVEL);
         rcount       <= rcount_next;
         underflow    <= r_en & empty;
      end
   assign raddr = b_rptr[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_rptr_ctrl_param.sv
// tb_rptr_ctrl_param: randomized and directed check of rptr_ctrl_param against a delayed-pointer arithmetic model.
module tb_rptr_ctrl_param;
   localparam int AW = 3, S = 2, AE = 1, N = 2 ** AW, M = 2 * N;
   logic rclk = 0, rrst_n = 0, r_en = 0;
   logic [AW:0] g_wptr_async = '0, b_rptr, g_rptr, rcount;
   logic [AW-1:0] raddr;
   logic empty, almost_empty, underflow;
   int checks = 0, errors = 0;
   int unsigned m_r, m_cnt, w;
   bit m_empty, m_ae, m_uf;
   int unsigned hist[$];
   rptr_ctrl_param #(.ADDR_WIDTH(AW), .SYNC_STAGES(S), .AE_LEVEL(AE)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .r_en(r_en), .g_wptr_async(g_wptr_async),
      .b_rptr(b_rptr), .g_rptr(g_rptr), .raddr(raddr), .empty(empty),
      .almost_empty(almost_empty), .rcount(rcount), .underflow(underflow));
   always #5 rclk = ~rclk;
   function automatic logic [AW:0] gray(int unsigned v);
      return (AW+1)'(v ^ (v >> 1));
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_r = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_uf = 0;
      hist = {};
      repeat (S) hist.push_back(0);
   endtask
   task automatic check_all();
      chk("b_rptr", b_rptr, m_r);
      chk("g_rptr", g_rptr, gray(m_r));
      chk("raddr", raddr, m_r % N);
      chk("empty", empty, m_empty);
      chk("almost_empty", almost_empty, m_ae);
      chk("rcount", rcount, m_cnt);
      chk("underflow", underflow, m_uf);
   endtask
   // Entered and left at a falling edge; the synchronised write pointer is the
   // value presented S rising edges earlier.
   task automatic step(input bit re, input int unsigned wv);
      int unsigned ws;
      bit ok;
      r_en = re;
      g_wptr_async = gray(wv);
      @(posedge rclk);
      ws = hist.pop_front();
      hist.push_back(wv);
      ok = re && !m_empty;
      m_uf = re && m_empty;
      m_r = (m_r + (ok ? 1 : 0)) % M;
      m_cnt = (ws + M - m_r) % M;
      m_empty = m_cnt == 0;
      m_ae = m_cnt <= AE;
      @(negedge rclk);
      check_all();
   endtask
   task automatic mid_reset();
      #2 rrst_n = 0;
      #1 model_reset();
      check_all();
      @(negedge rclk);
      rrst_n = 1;
   endtask
   initial begin
      model_reset();
      @(negedge rclk);
      rrst_n = 1;
      repeat (2) step(1, 0);
      mid_reset();
      w = 3;
      repeat (2) step(0, w);
      chk("vis_empty_held", empty, 1);
      step(0, w);
      chk("vis_rcount", rcount, 3);
      chk("vis_empty", empty, 0);
      repeat (3) step(1, w);
      chk("drain_b_rptr", b_rptr, 3);
      chk("drain_g_rptr", g_rptr, 4'b0010);
      chk("drain_empty", empty, 1);
      step(1, w);
      chk("uf_pulse", underflow, 1);
      chk("uf_hold", b_rptr, 3);
      step(0, w);
      chk("uf_clear", underflow, 0);
      w = 7;
      repeat (3) step(0, w);
      repeat (4) step(1, w);
      w = 9;
      repeat (3) step(0, w);
      chk("wrap_rcount", rcount, 2);
      chk("wrap_g0", g_rptr, 4'b0100);
      step(1, w);
      chk("wrap_raddr0", raddr, 0);
      chk("wrap_g1", g_rptr, 4'b1100);
      step(1, w);
      chk("wrap_raddr1", raddr, 1);
      chk("wrap_g2", g_rptr, 4'b1101);
      chk("wrap_empty", empty, 1);
      mid_reset();
      w = 5;
      repeat (3) step(0, w);
      chk("mid_rcount", rcount, 5);
      r_en = 1;
      mid_reset();
      repeat (2) step(0, w);
      chk("rel_empty_held", empty, 1);
      step(0, w);
      chk("rel_empty", empty, 0);
      chk("rel_rcount", rcount, 5);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            r_en = $urandom_range(0, 1);
            mid_reset();
            w = $urandom_range(0, N);
         end
         if ((w + M - m_r) % M < N && $urandom_range(0, 2) != 0) w = (w + 1) % M;
         step($urandom_range(0, 1), w);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rptr_ctrl_param.md
Name: rptr_ctrl_param

Overview:
- Parametrised read-side pointer and flag controller for the asynchronous FIFO, in the read clock domain.
- Synchronises the Gray write pointer internally and decodes it to binary.
- Generates binary/Gray read pointers, RAM read address, registered empty, almost_empty, read-side occupancy count and an underflow pulse.
- Successor to the fixed-function read pointer handler. Adds configurable depth, synchroniser length, almost-empty threshold, occupancy reporting and underflow detection.

Parameters:
- ADDR_WIDTH, 3, FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2, flops in the write-pointer synchroniser; legal range >= 2.
- AE_LEVEL, 1, almost_empty asserts when occupancy <= AE_LEVEL; legal range 0 .. 2^ADDR_WIDTH-1.

Ports:
- rclk  input  1  read-domain clock
- rrst_n  input  1  reset, asynchronous, active-low
- r_en  input  1  read request from consumer
- g_wptr_async  input  ADDR_WIDTH+1  Gray write pointer from write domain, unsynchronised
- b_rptr  output  ADDR_WIDTH+1  binary read pointer (registered)
- g_rptr  output  ADDR_WIDTH+1  Gray read pointer (registered), sent to write domain
- raddr  output  ADDR_WIDTH  RAM read address = b_rptr[ADDR_WIDTH-1:0]
- empty  output  1  FIFO empty (registered)
- almost_empty  output  1  occupancy <= AE_LEVEL (registered)
- rcount  output  ADDR_WIDTH+1  read-side occupancy, 0 .. 2^ADDR_WIDTH (registered)
- underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset (asynchronous, any time, including mid-operation) clears all state:
  - synchroniser flops = 0, b_rptr = 0, g_rptr = 0
  - empty = 1, almost_empty = 1, rcount = 0, underflow = 0
- Synchroniser: SYNC_STAGES-deep flop chain on g_wptr_async; last stage = g_wptr_sync.
- Write-pointer decode: b_wptr_s = Gray-to-binary(g_wptr_sync), combinational XOR prefix from MSB down.
- Read acceptance: rd_ok = r_en & ~empty. A read is accepted only when empty = 0 at the rclk edge.
- Pointer update:
  - b_rptr_next = b_rptr + rd_ok, modulo 2^(ADDR_WIDTH+1)
  - g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1)
  - both registered on each rclk edge
- empty_next = (g_rptr_next == g_wptr_sync); registered.
- rcount_next = (b_wptr_s - b_rptr_next) modulo 2^(ADDR_WIDTH+1); registered.
- almost_empty_next = (rcount_next <= AE_LEVEL); registered. empty = 1 implies almost_empty = 1.
- underflow registered = r_en & empty. Pointers do not move on an underflow cycle.
- Latency:
  - A g_wptr_async change reaches g_wptr_sync after SYNC_STAGES rclk edges.
  - empty, rcount and almost_empty update one further edge later: SYNC_STAGES+1 total.
  - A read affects empty/rcount at the same edge that advances b_rptr.
- Flags are pessimistic: empty may stay asserted after a write, but must never deassert while the FIFO is truly empty. rcount may under-report, never over-report.
- Wrap-around: the pointer MSB toggles every 2^ADDR_WIDTH reads. raddr wraps 2^ADDR_WIDTH-1 -> 0. g_rptr changes exactly one bit per accepted read.
- Simultaneous read and pointer update on the same edge: rcount reflects both (new b_wptr_s, advanced b_rptr).
- g_rptr is driven directly from a flop, with no combinational logic after it, because it crosses clock domains.

Test Plan:
1. Reset check (ADDR_WIDTH=3, SYNC_STAGES=2, AE_LEVEL=1): assert rrst_n=0 mid-clock -> immediately b_rptr=0, g_rptr=0, raddr=0, empty=1, almost_empty=1, rcount=0, underflow=0.
2. Write visibility: g_wptr_async=4'b0010 (binary 3), r_en=0 -> empty=1 for 2 edges; on the 3rd edge empty=0, rcount=3, almost_empty=0.
3. Drain: from case 2, r_en=1 for 3 cycles -> rcount 2,1,0; almost_empty=1 from rcount=1; empty=1 after the 3rd read; b_rptr=3, g_rptr=4'b0010; underflow stays 0.
4. Underflow: empty=1, r_en=1 for 1 cycle -> underflow=1 for exactly one cycle; b_rptr/g_rptr unchanged.
5. Wrap: b_rptr=7, synced write pointer binary 9 (Gray 4'b1101) -> rcount=2. Two reads -> raddr 7->0->1, g_rptr 4'b0100->4'b1100->4'b1101; empty=1 after the second read.
6. Reset mid-operation: rcount=5 with r_en=1, pulse rrst_n low -> all outputs return to reset values asynchronously. After release with the write pointer still at 5, empty deasserts 3 edges later with rcount=5.
